// File: rtl/fwd_pkg.sv
// Shared constants, FSM state type and sizing helper for the EX-stage forwarding/hazard unit.
package fwd_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_STALL = 1'b1
   } fsm_state_t;

   // Bubble down-counter width; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned lat);
      int unsigned w;
      w = $clog2(lat);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-source forward select: MEM result beats WB result, register 0 and dead slots never forward.
module fwd_select
   import fwd_pkg::*;
#(
   parameter int unsigned AW = 5
)
(
   input  logic          ex_valid,
   input  logic [AW-1:0] rs,
   input  logic          rs_use,
   input  logic [AW-1:0] rd_mem,
   input  logic          reg_write_mem,
   input  logic [AW-1:0] rd_wb,
   input  logic          reg_write_wb,
   output logic [1:0]    sel_c
);

   always_comb begin
      sel_c = FWD_RF;
      if (ex_valid && rs_use && (rs != '0)) begin
         if (reg_write_mem && (rd_mem == rs)) begin
            sel_c = FWD_MEM;
         end else if (reg_write_wb && (rd_wb == rs)) begin
            sel_c = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding and load-use hazard unit: forward selects, LOAD_LAT-cycle stall FSM,
// EX validity tracking and a saturating stall-cycle counter.
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int unsigned NUM_SRC  = 2,
   parameter int unsigned AW       = 5,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned CNT_W    = 16
)
(
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   ID_VALID,
   input  logic [NUM_SRC*AW-1:0]  RS_ID,
   input  logic [NUM_SRC-1:0]     RS_USE_ID,
   input  logic [NUM_SRC*AW-1:0]  RS_EX,
   input  logic [NUM_SRC-1:0]     RS_USE_EX,
   input  logic                   ID_EX_WE,
   input  logic [AW-1:0]          RD_EX,
   input  logic                   memRead_EX,
   input  logic [AW-1:0]          RD_MEM,
   input  logic                   regWrite_MEM,
   input  logic [AW-1:0]          RD_WB,
   input  logic                   regWrite_WB,
   input  logic                   FLUSH,
   output logic [NUM_SRC*2-1:0]   forwardSel,
   output logic                   stall,
   output logic [CNT_W-1:0]       stallCount
);

   localparam int unsigned    CW          = cnt_width(LOAD_LAT);
   localparam bit             MULTI_CYCLE = (LOAD_LAT > 1);
   localparam logic [CW-1:0]  CNT_INIT    = CW'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);

   fsm_state_t    state;
   fsm_state_t    state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          ex_valid;
   logic          rs_match_c;
   logic          hazard_c;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      fwd_select #(.AW(AW)) u_sel (
         .ex_valid      (ex_valid),
         .rs            (RS_EX[g*AW +: AW]),
         .rs_use        (RS_USE_EX[g]),
         .rd_mem        (RD_MEM),
         .reg_write_mem (regWrite_MEM),
         .rd_wb         (RD_WB),
         .reg_write_wb  (regWrite_WB),
         .sel_c         (forwardSel[g*2 +: 2])
      );
   end

   // Load-use: a live load in EX whose destination is read by the live ID instruction.
   always_comb begin
      rs_match_c = 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (RS_USE_ID[i] && (RS_ID[i*AW +: AW] == RD_EX)) begin
            rs_match_c = 1'b1;
         end
      end
      hazard_c = ID_VALID && ex_valid && memRead_EX && (RD_EX != '0) && rs_match_c;
   end

   // First bubble is issued combinationally in IDLE; STALL covers the remaining LOAD_LAT-1.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall     = 1'b0;
      case (state)
         S_IDLE: begin
            stall = hazard_c && !FLUSH;
            if (stall && MULTI_CYCLE) begin
               state_nxt = S_STALL;
               cnt_nxt   = CNT_INIT;
            end
         end
         S_STALL: begin
            stall = !FLUSH;
            if (FLUSH || (cnt == '0)) begin
               state_nxt = S_IDLE;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ex_valid <= 1'b0;
      end else if (FLUSH || stall) begin
         ex_valid <= 1'b0;
      end else if (ID_EX_WE) begin
         ex_valid <= ID_VALID;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         stallCount <= '0;
      end else if (stall && (stallCount != '1)) begin
         stallCount <= stallCount + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two instances (LOAD_LAT=3/CNT_W=4 and LOAD_LAT=1/CNT_W=16) on shared stimulus.
module tb_fwd_hazard_unit;

   localparam int NS = 2;
   localparam int AW = 5;

   logic              CLK = 1'b0;
   logic              RST;
   logic              ID_VALID;
   logic [NS*AW-1:0]  RS_ID;
   logic [NS-1:0]     RS_USE_ID;
   logic [NS*AW-1:0]  RS_EX;
   logic [NS-1:0]     RS_USE_EX;
   logic              ID_EX_WE;
   logic [AW-1:0]     RD_EX;
   logic              memRead_EX;
   logic [AW-1:0]     RD_MEM;
   logic              regWrite_MEM;
   logic [AW-1:0]     RD_WB;
   logic              regWrite_WB;
   logic              FLUSH;

   logic [NS*2-1:0]   fsel_a, fsel_b;
   logic              stall_a, stall_b;
   logic [3:0]        cnt_a;
   logic [15:0]       cnt_b;

   always #5 CLK = ~CLK;

   fwd_hazard_unit #(.NUM_SRC(NS), .AW(AW), .LOAD_LAT(3), .CNT_W(4)) dut_a (
      .CLK(CLK), .RST(RST), .ID_VALID(ID_VALID), .RS_ID(RS_ID), .RS_USE_ID(RS_USE_ID),
      .RS_EX(RS_EX), .RS_USE_EX(RS_USE_EX), .ID_EX_WE(ID_EX_WE), .RD_EX(RD_EX),
      .memRead_EX(memRead_EX), .RD_MEM(RD_MEM), .regWrite_MEM(regWrite_MEM),
      .RD_WB(RD_WB), .regWrite_WB(regWrite_WB), .FLUSH(FLUSH),
      .forwardSel(fsel_a), .stall(stall_a), .stallCount(cnt_a)
   );

   fwd_hazard_unit #(.NUM_SRC(NS), .AW(AW), .LOAD_LAT(1), .CNT_W(16)) dut_b (
      .CLK(CLK), .RST(RST), .ID_VALID(ID_VALID), .RS_ID(RS_ID), .RS_USE_ID(RS_USE_ID),
      .RS_EX(RS_EX), .RS_USE_EX(RS_USE_EX), .ID_EX_WE(ID_EX_WE), .RD_EX(RD_EX),
      .memRead_EX(memRead_EX), .RD_MEM(RD_MEM), .regWrite_MEM(regWrite_MEM),
      .RD_WB(RD_WB), .regWrite_WB(regWrite_WB), .FLUSH(FLUSH),
      .forwardSel(fsel_b), .stall(stall_b), .stallCount(cnt_b)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit checking = 1'b0;

   // Model state per instance: EX validity, stall cycles still owed, stall-cycle count.
   bit m_ev   [2];
   int m_left [2];
   int m_cnt  [2];
   int LAT    [2] = '{3, 1};
   int CMAX   [2] = '{15, 65535};

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [NS*2-1:0] m_fwd(input bit ev);
      logic [NS*2-1:0] r;
      logic [AW-1:0]   rs;
      r = '0;
      for (int i = 0; i < NS; i++) begin
         rs = RS_EX[i*AW +: AW];
         if (ev && RS_USE_EX[i] && rs != 0) begin
            if (regWrite_MEM && RD_MEM == rs)     r[i*2 +: 2] = 2'b10;
            else if (regWrite_WB && RD_WB == rs)  r[i*2 +: 2] = 2'b01;
         end
      end
      return r;
   endfunction

   function automatic bit m_hazard(input bit ev);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < NS; i++)
         if (RS_USE_ID[i] && RS_ID[i*AW +: AW] == RD_EX) hit = 1'b1;
      return ID_VALID && ev && memRead_EX && RD_EX != 0 && hit;
   endfunction

   function automatic bit m_stall(input int k);
      if (FLUSH) return 1'b0;
      if (m_left[k] > 0) return 1'b1;
      return m_hazard(m_ev[k]);
   endfunction

   always @(posedge CLK) begin
      for (int k = 0; k < 2; k++) begin
         bit st, hz;
         st = m_stall(k);
         hz = m_hazard(m_ev[k]);
         if (RST) begin
            m_ev[k] = 1'b0; m_left[k] = 0; m_cnt[k] = 0;
         end else begin
            if (st && m_cnt[k] < CMAX[k]) m_cnt[k] = m_cnt[k] + 1;
            if (FLUSH)              m_left[k] = 0;
            else if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
            else if (hz)            m_left[k] = LAT[k] - 1;
            if (FLUSH || st)   m_ev[k] = 1'b0;
            else if (ID_EX_WE) m_ev[k] = ID_VALID;
         end
      end
      if (RST) checking = 1'b1;
   end

   always @(negedge CLK) begin
      if (checking) begin
         check("m_fsel_a",  32'(fsel_a),  32'(m_fwd(m_ev[0])));
         check("m_stall_a", 32'(stall_a), 32'(m_stall(0)));
         check("m_cnt_a",   32'(cnt_a),   32'(m_cnt[0]));
         check("m_fsel_b",  32'(fsel_b),  32'(m_fwd(m_ev[1])));
         check("m_stall_b", 32'(stall_b), 32'(m_stall(1)));
         check("m_cnt_b",   32'(cnt_b),   32'(m_cnt[1]));
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; ID_VALID = 1'b0; RS_ID = '0; RS_USE_ID = '0; RS_EX = '0; RS_USE_EX = '0;
      ID_EX_WE = 1'b0; RD_EX = '0; memRead_EX = 1'b0; RD_MEM = '0; regWrite_MEM = 1'b0;
      RD_WB = '0; regWrite_WB = 1'b0; FLUSH = 1'b0;
      step(); step();
      RST = 1'b0;
      #2;
      check("rst_stall_a", 32'(stall_a), 0);
      check("rst_fsel_a",  32'(fsel_a),  0);
      check("rst_cnt_a",   32'(cnt_a),   0);
      check("rst_cnt_b",   32'(cnt_b),   0);

      // Load a live EX slot, then forward src0 from MEM and src1 from WB.
      step(); ID_VALID = 1'b1; ID_EX_WE = 1'b1;
      step(); ID_EX_WE = 1'b0; RS_EX = {5'd2, 5'd1}; RS_USE_EX = 2'b11;
      RD_MEM = 5'd1; regWrite_MEM = 1'b1; RD_WB = 5'd2; regWrite_WB = 1'b1;
      #2 check("fwd_split", 32'(fsel_a), 32'h6);

      step(); RD_MEM = 5'd3; RD_WB = 5'd3; RS_EX = {5'd2, 5'd3};
      #2 check("fwd_mem_wins", 32'(fsel_b), 32'h2);
      step(); regWrite_MEM = 1'b0;
      #2 check("fwd_wb_only", 32'(fsel_b), 32'h1);
      step(); RS_EX = {5'd2, 5'd0};
      #2 check("fwd_r0", 32'(fsel_a), 32'h0);

      // Load-use hazard on src1.
      step(); RS_EX = {5'd2, 5'd1}; RD_MEM = 5'd1; regWrite_MEM = 1'b1; RD_WB = 5'd2; regWrite_WB = 1'b1;
      memRead_EX = 1'b1; RD_EX = 5'd5; RS_ID = {5'd5, 5'd9}; RS_USE_ID = 2'b10;
      #2 check("lu_stall_b0", 32'(stall_b), 1);
      check("lu_stall_a0", 32'(stall_a), 1);
      check("lu_fsel_live", 32'(fsel_a), 32'h6);
      step();
      #2 check("lu_stall_b1", 32'(stall_b), 0);
      check("lu_fsel_b1", 32'(fsel_b), 0);
      check("lu_cnt_b1", 32'(cnt_b), 1);
      check("lu_stall_a1", 32'(stall_a), 1);
      step();
      #2 check("lu_stall_a2", 32'(stall_a), 1);
      step();
      #2 check("lu_stall_a3", 32'(stall_a), 0);
      check("lu_cnt_a3", 32'(cnt_a), 3);

      // Unused source, then r0 destination: no stall.
      step(); memRead_EX = 1'b0; ID_EX_WE = 1'b1;
      step(); ID_EX_WE = 1'b0; memRead_EX = 1'b1; RS_USE_ID = 2'b01;
      #2 check("nouse_stall_a", 32'(stall_a), 0);
      check("nouse_fsel", 32'(fsel_a), 32'h6);
      step(); RS_USE_ID = 2'b10; RD_EX = 5'd0; RS_ID = {5'd0, 5'd9};
      #2 check("r0_stall_a", 32'(stall_a), 0);
      check("r0_stall_b", 32'(stall_b), 0);

      // Flush in the second stall cycle.
      step(); RD_EX = 5'd5; RS_ID = {5'd5, 5'd9};
      #2 check("fl_stall_a0", 32'(stall_a), 1);
      step(); FLUSH = 1'b1;
      #2 check("fl_stall_a1", 32'(stall_a), 0);
      step(); FLUSH = 1'b0;
      #2 check("fl_stall_a2", 32'(stall_a), 0);
      check("fl_fsel_a2", 32'(fsel_a), 0);
      check("fl_cnt_a2", 32'(cnt_a), 4);
      check("fl_cnt_b2", 32'(cnt_b), 2);

      // Six more hazards: instance A saturates at 15.
      repeat (6) begin
         step(); memRead_EX = 1'b0; ID_EX_WE = 1'b1;
         step(); ID_EX_WE = 1'b0; memRead_EX = 1'b1;
         step(); step();
      end
      step();
      #2 check("sat_cnt_a", 32'(cnt_a), 15);
      check("sat_cnt_b", 32'(cnt_b), 8);

      // Reset in the middle of a stall.
      step(); memRead_EX = 1'b0; ID_EX_WE = 1'b1;
      step(); ID_EX_WE = 1'b0; memRead_EX = 1'b1;
      #2 check("rs_stall_a0", 32'(stall_a), 1);
      step(); RST = 1'b1;
      #2 check("rs_stall_a1", 32'(stall_a), 1);
      step(); RST = 1'b0;
      #2 check("rs_stall_a2", 32'(stall_a), 0);
      check("rs_fsel_a2", 32'(fsel_a), 0);
      check("rs_cnt_a2", 32'(cnt_a), 0);
      check("rs_cnt_b2", 32'(cnt_b), 0);

      // Randomized traffic against the model.
      repeat (3000) begin
         step();
         RST          = ($urandom_range(0, 99) == 0);
         FLUSH        = ($urandom_range(0, 9) == 0);
         ID_VALID     = 1'($urandom_range(0, 1));
         ID_EX_WE     = ($urandom_range(0, 3) != 0);
         RS_ID        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         RS_USE_ID    = 2'($urandom_range(0, 3));
         RS_EX        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         RS_USE_EX    = 2'($urandom_range(0, 3));
         RD_EX        = 5'($urandom_range(0, 7));
         memRead_EX   = 1'($urandom_range(0, 1));
         RD_MEM       = 5'($urandom_range(0, 7));
         regWrite_MEM = 1'($urandom_range(0, 1));
         RD_WB        = 5'($urandom_range(0, 7));
         regWrite_WB  = 1'($urandom_range(0, 1));
      end
      step();
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
